// File: rtl/exc_pkg.sv
// Shared ExcCodes, exception-flag bit positions and FSM/selector types for the commit-point exception unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package exc_pkg;

  // ExcCode values written into Cause.ExcCode
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  // Bit positions inside the 7-bit per-instruction exception flag vector
  localparam int EXC_FLAG_W      = 7;
  localparam int EXC_BIT_IF_ADEL = 6;
  localparam int EXC_BIT_RI      = 5;
  localparam int EXC_BIT_OV      = 4;
  localparam int EXC_BIT_SYS     = 3;
  localparam int EXC_BIT_BP      = 2;
  localparam int EXC_BIT_ADEL    = 1;
  localparam int EXC_BIT_ADES    = 0;

  // Source of BadVAddr for the selected event
  typedef enum logic [1:0] {
    BV_NONE = 2'd0,
    BV_PC   = 2'd1,
    BV_DATA = 2'd2
  } bv_sel_t;

  // Redirect FSM
  typedef enum logic {
    IDLE  = 1'b0,
    REDIR = 1'b1
  } exc_state_t;

endpackage

// File: rtl/exc_priority_enc.sv
// Fixed-priority selector: picks one event from interrupt, exception flags and ERET.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller decides whether the result commits.
module exc_priority_enc
  import exc_pkg::*;
(
  input  logic [EXC_FLAG_W-1:0] exc,
  input  logic                  int_take,
  input  logic                  eret,
  output logic                  valid,
  output logic [4:0]            code,
  output bv_sel_t               badvaddr_sel,
  output logic                  is_eret
);

  // Highest-priority event wins; ERET only when nothing else is pending
  always_comb begin
    valid        = 1'b1;
    code         = EXC_INT;
    badvaddr_sel = BV_NONE;
    is_eret      = 1'b0;
    if (int_take) begin
      code = EXC_INT;
    end else if (exc[EXC_BIT_IF_ADEL]) begin
      code         = EXC_ADEL;
      badvaddr_sel = BV_PC;
    end else if (exc[EXC_BIT_RI]) begin
      code = EXC_RI;
    end else if (exc[EXC_BIT_OV]) begin
      code = EXC_OV;
    end else if (exc[EXC_BIT_SYS]) begin
      code = EXC_SYS;
    end else if (exc[EXC_BIT_BP]) begin
      code = EXC_BP;
    end else if (exc[EXC_BIT_ADEL]) begin
      code         = EXC_ADEL;
      badvaddr_sel = BV_DATA;
    end else if (exc[EXC_BIT_ADES]) begin
      code         = EXC_ADES;
      badvaddr_sel = BV_DATA;
    end else if (eret) begin
      is_eret = 1'b1;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/exception_unit.sv
// Commit-point exception arbiter: drives the cp0 exception write port, flushes and redirects fetch.
// Latency: cp0 write and flush in the commit cycle; redirect_valid from the next cycle.
// Backpressure: redirect held (and MEM ignored) until redirect_ready is seen.
module exception_unit
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic                  mem_stall,
  input  logic [31:0]           mem_pc,
  input  logic                  mem_is_branch,
  input  logic                  mem_eret,
  input  logic [EXC_FLAG_W-1:0] mem_exc,
  input  logic [31:0]           mem_data_addr,
  input  logic                  allow_interrupt,
  input  logic [7:0]            interrupt_flag,
  input  logic [31:0]           epc_address,
  output logic                  exp_en,
  output logic                  exp_badvaddr_en,
  output logic [31:0]           exp_badvaddr,
  output logic                  exp_bd,
  output logic [4:0]            exp_code,
  output logic [31:0]           exp_epc,
  output logic                  exl_clean,
  output logic                  flush,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc,
  input  logic                  redirect_ready
);

  exc_state_t  state, state_nxt;
  logic        in_ds;
  logic        commit;
  logic        int_take;
  logic        ev_valid;
  logic [4:0]  ev_code;
  bv_sel_t     ev_bv_sel;
  logic        ev_is_eret;

  assign int_take = allow_interrupt & (|interrupt_flag);
  assign commit   = mem_valid & ~mem_stall & (state == IDLE);

  exc_priority_enc u_enc (
    .exc          (mem_exc),
    .int_take     (int_take),
    .eret         (mem_eret),
    .valid        (ev_valid),
    .code         (ev_code),
    .badvaddr_sel (ev_bv_sel),
    .is_eret      (ev_is_eret)
  );

  // cp0 write port, sampled by cp0 on the same edge as the commit
  always_comb begin
    exp_en          = rst & commit & ev_valid;
    exp_code        = ev_code;
    exp_bd          = ev_is_eret ? 1'b0 : in_ds;
    exl_clean       = exp_en & ev_is_eret;
    exp_badvaddr_en = exp_en & (ev_bv_sel != BV_NONE);
    exp_badvaddr    = 32'h0;
    if (ev_bv_sel == BV_PC)   exp_badvaddr = mem_pc;
    if (ev_bv_sel == BV_DATA) exp_badvaddr = mem_data_addr;
    if (ev_is_eret)  exp_epc = epc_address;
    else if (in_ds)  exp_epc = mem_pc - 32'd4;
    else             exp_epc = mem_pc;
  end

  // Flush covers the commit cycle and the whole redirect handshake
  assign flush          = rst & (exp_en | (state == REDIR));
  assign redirect_valid = (state == REDIR);

  // Next-state: enter REDIR on a taken event, leave once fetch accepts
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (exp_en) state_nxt = REDIR;
      REDIR:   if (redirect_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Redirect target is latched at commit so it stays stable through REDIR
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        redirect_pc <= 32'h0;
    else if (exp_en) redirect_pc <= ev_is_eret ? epc_address : EXC_VECTOR;
  end

  // Delay-slot tracking: set by a committed, non-excepting branch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        in_ds <= 1'b0;
    else if (flush)  in_ds <= 1'b0;
    else if (commit) in_ds <= mem_is_branch;
  end

endmodule

// File: tb/tb_exception_unit.sv
// Directed bench for exception_unit: vector table plus handshake/stall/reset sequences.
// Latency: checks cp0 outputs in the commit cycle and redirect one cycle later.
// Backpressure: exercises redirect_ready held low and released.
module tb_exception_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_stall, mem_is_branch, mem_eret;
  logic [31:0] mem_pc, mem_data_addr, epc_address;
  logic [6:0]  mem_exc;
  logic        allow_interrupt;
  logic [7:0]  interrupt_flag;
  logic        exp_en, exp_badvaddr_en, exp_bd, exl_clean, flush, redirect_valid;
  logic [31:0] exp_badvaddr, exp_epc, redirect_pc;
  logic [4:0]  exp_code;
  logic        redirect_ready;

  int tests  = 0;
  int failed = 0;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  always #5 clk = ~clk;

  exception_unit dut (
    .clk             (clk),
    .rst             (rst),
    .mem_valid       (mem_valid),
    .mem_stall       (mem_stall),
    .mem_pc          (mem_pc),
    .mem_is_branch   (mem_is_branch),
    .mem_eret        (mem_eret),
    .mem_exc         (mem_exc),
    .mem_data_addr   (mem_data_addr),
    .allow_interrupt (allow_interrupt),
    .interrupt_flag  (interrupt_flag),
    .epc_address     (epc_address),
    .exp_en          (exp_en),
    .exp_badvaddr_en (exp_badvaddr_en),
    .exp_badvaddr    (exp_badvaddr),
    .exp_bd          (exp_bd),
    .exp_code        (exp_code),
    .exp_epc         (exp_epc),
    .exl_clean       (exl_clean),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .redirect_ready  (redirect_ready)
  );

  typedef struct {
    logic        valid, stall, br, eret;
    logic [31:0] pc, addr, epc_in;
    logic [6:0]  exc;
    logic        allow;
    logic [7:0]  iflag;
    logic        e_en;
    logic [4:0]  e_code;
    logic [31:0] e_epc;
    logic        e_bd, e_bven;
    logic [31:0] e_bv;
    logic        e_exl;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0; mem_stall = 1'b0; mem_is_branch = 1'b0; mem_eret = 1'b0;
    mem_exc = 7'h0; mem_pc = 32'h0; mem_data_addr = 32'h0;
    allow_interrupt = 1'b0; interrupt_flag = 8'h0; epc_address = 32'h0;
  endtask

  // Called at a negedge in REDIR: check redirect, accept it, check it drops
  task automatic drain(input string tag, input logic [31:0] rpc);
    chk({tag, "_rvalid"}, {31'h0, redirect_valid}, 32'h1);
    chk({tag, "_rpc"}, redirect_pc, rpc);
    chk({tag, "_rflush"}, {31'h0, flush}, 32'h1);
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    redirect_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_rdone"}, {31'h0, redirect_valid}, 32'h0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    @(posedge clk); #1;
    mem_valid = v.valid; mem_stall = v.stall; mem_is_branch = v.br; mem_eret = v.eret;
    mem_pc = v.pc; mem_data_addr = v.addr; epc_address = v.epc_in; mem_exc = v.exc;
    allow_interrupt = v.allow; interrupt_flag = v.iflag;
    @(negedge clk);
    chk({t, "_en"},    {31'h0, exp_en}, {31'h0, v.e_en});
    chk({t, "_code"},  {27'h0, exp_code}, {27'h0, v.e_code});
    chk({t, "_epc"},   exp_epc, v.e_epc);
    chk({t, "_bd"},    {31'h0, exp_bd}, {31'h0, v.e_bd});
    chk({t, "_bven"},  {31'h0, exp_badvaddr_en}, {31'h0, v.e_bven});
    chk({t, "_bv"},    exp_badvaddr, v.e_bv);
    chk({t, "_exl"},   {31'h0, exl_clean}, {31'h0, v.e_exl});
    chk({t, "_flush"}, {31'h0, flush}, {31'h0, v.e_en});
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    if (v.e_en) drain(t, v.e_rpc);
    else chk({t, "_norv"}, {31'h0, redirect_valid}, 32'h0);
  endtask

  initial begin
    //           valid stall br    eret  pc            addr          epc_in        exc         allow iflag  en    code   epc           bd    bven  bv            exl   rpc
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_1000, 32'h0,        32'h0,        7'b0010000, 1'b0, 8'h00, 1'b1, 5'h0C, 32'h8000_1000, 1'b0, 1'b0, 32'h0,        1'b0, VEC};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0,        32'h0,        7'b0000000, 1'b0, 8'h00, 1'b0, 5'h00, 32'h0000_0100, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0104, 32'h0000_0003, 32'h0,       7'b0000010, 1'b0, 8'h00, 1'b1, 5'h04, 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0003, 1'b0, VEC};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 32'h0,        32'h0,        7'b0001000, 1'b1, 8'h04, 1'b1, 5'h00, 32'h0000_0200, 1'b0, 1'b0, 32'h0,        1'b0, VEC};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 32'h0,        32'h0,        7'b0001000, 1'b0, 8'h04, 1'b1, 5'h08, 32'h0000_0200, 1'b0, 1'b0, 32'h0,        1'b0, VEC};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0300, 32'h0,        32'h8000_2000, 7'b0000000, 1'b0, 8'h00, 1'b1, 5'h00, 32'h8000_2000, 1'b0, 1'b0, 32'h0,        1'b1, 32'h8000_2000};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0400, 32'h0,        32'h8000_2000, 7'b0000000, 1'b1, 8'h80, 1'b1, 5'h00, 32'h0000_0400, 1'b0, 1'b0, 32'h0,        1'b0, VEC};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0005, 32'h0,        32'h0,        7'b1100000, 1'b0, 8'h00, 1'b1, 5'h04, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0005, 1'b0, VEC};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0500, 32'h0000_1001, 32'h0,       7'b0000001, 1'b0, 8'h00, 1'b1, 5'h05, 32'h0000_0500, 1'b0, 1'b1, 32'h0000_1001, 1'b0, VEC};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0504, 32'h0000_1001, 32'h0,       7'b0000101, 1'b0, 8'h00, 1'b1, 5'h09, 32'h0000_0504, 1'b0, 1'b0, 32'h0,        1'b0, VEC};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0900, 32'h0,        32'h0,        7'b0010000, 1'b0, 8'h00, 1'b0, 5'h0C, 32'h0000_0900, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,        32'h0,        7'b0000000, 1'b0, 8'h00, 1'b0, 5'h00, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0,        32'h0,        7'b0010000, 1'b0, 8'h00, 1'b1, 5'h0C, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,        1'b0, VEC};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0600, 32'h0,        32'h0,        7'b0100000, 1'b0, 8'h00, 1'b1, 5'h0A, 32'h0000_0600, 1'b0, 1'b0, 32'h0,        1'b0, VEC};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0604, 32'h0,        32'h0,        7'b0001000, 1'b0, 8'h00, 1'b1, 5'h08, 32'h0000_0604, 1'b0, 1'b0, 32'h0,        1'b0, VEC};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0700, 32'h0,        32'h8000_2000, 7'b0010000, 1'b0, 8'h00, 1'b1, 5'h0C, 32'h0000_0700, 1'b0, 1'b0, 32'h0,        1'b0, VEC};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0800, 32'h0,        32'h0,        7'b0000000, 1'b1, 8'h01, 1'b1, 5'h00, 32'h0000_0800, 1'b0, 1'b0, 32'h0,        1'b0, VEC};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0804, 32'h0,        32'h0,        7'b0000000, 1'b1, 8'h00, 1'b0, 5'h00, 32'h0000_0804, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};

    // Reset: outputs quiet even with an excepting instruction presented
    redirect_ready = 1'b0;
    idle_inputs();
    rst = 1'b0;
    mem_valid = 1'b1; mem_exc = 7'b0010000; mem_pc = 32'h1234_0000;
    @(negedge clk);
    chk("rst_en", {31'h0, exp_en}, 32'h0);
    chk("rst_flush", {31'h0, flush}, 32'h0);
    chk("rst_rvalid", {31'h0, redirect_valid}, 32'h0);
    chk("rst_rpc", redirect_pc, 32'h0);
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b1;

    for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);

    // Redirect held while fetch is busy; MEM inputs ignored in REDIR
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_exc = 7'b0010000; mem_pc = 32'h8000_1000;
    @(negedge clk);
    chk("hold_en0", {31'h0, exp_en}, 32'h1);
    chk("hold_code0", {27'h0, exp_code}, 32'h0C);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("hold_rvalid%0d", c), {31'h0, redirect_valid}, 32'h1);
      chk($sformatf("hold_en%0d", c + 1), {31'h0, exp_en}, 32'h0);
      chk($sformatf("hold_flush%0d", c), {31'h0, flush}, 32'h1);
      chk($sformatf("hold_rpc%0d", c), redirect_pc, VEC);
    end
    idle_inputs();
    drain("hold", VEC);

    // Stall: ri waits until the stall drops
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_stall = 1'b1; mem_exc = 7'b0100000; mem_pc = 32'h0000_0A00;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("stall_en%0d", c), {31'h0, exp_en}, 32'h0);
      chk($sformatf("stall_flush%0d", c), {31'h0, flush}, 32'h0);
      @(posedge clk); #1;
    end
    mem_stall = 1'b0;
    @(negedge clk);
    chk("stall_en_go", {31'h0, exp_en}, 32'h1);
    chk("stall_code", {27'h0, exp_code}, 32'h0A);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    drain("stall", VEC);

    // Async reset in the middle of REDIR
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_exc = 7'b0000100; mem_pc = 32'h0000_0B00;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rvalid_pre", {31'h0, redirect_valid}, 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rvalid", {31'h0, redirect_valid}, 32'h0);
    chk("mid_flush", {31'h0, flush}, 32'h0);
    chk("mid_en", {31'h0, exp_en}, 32'h0);
    chk("mid_rpc", redirect_pc, 32'h0);
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_idle_rvalid", {31'h0, redirect_valid}, 32'h0);

    // Reset clears delay-slot state set by a committed branch
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_is_branch = 1'b1; mem_pc = 32'h0000_0C00;
    @(posedge clk); #1;
    idle_inputs();
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_exc = 7'b0010000; mem_pc = 32'h0000_0C04;
    @(negedge clk);
    chk("ds_rst_en", {31'h0, exp_en}, 32'h1);
    chk("ds_rst_bd", {31'h0, exp_bd}, 32'h0);
    chk("ds_rst_epc", exp_epc, 32'h0000_0C04);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    drain("ds_rst", VEC);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Global time limit so the run always ends with a summary
  initial begin
    #200000;
    failed++;
    $display("FAIL timeout: got running expected finished");
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/exception_unit.md
Name: exception_unit

Overview:
- Commit-point exception arbiter in the MEM stage, directly upstream of cp0.
- Collects per-instruction exception flags, pending interrupts and ERET, then selects one event per committed instruction by fixed priority.
- Drives cp0's exception write port (exp_en, exp_code, exp_epc, exp_bd, exp_badvaddr, exl_clean).
- Flushes the pipeline and redirects fetch to the exception vector or EPC, using a handshake held until fetch accepts.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, general exception entry address.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- mem_valid  in  1  MEM stage holds a real instruction
- mem_stall  in  1  MEM stalled; nothing commits this cycle
- mem_pc  in  32  PC of MEM instruction
- mem_is_branch  in  1  MEM instruction is a branch/jump (next instruction is its delay slot)
- mem_eret  in  1  MEM instruction is ERET
- mem_exc  in  7  flags {if_adel, ri, ov, sys, bp, adel, ades}, bit 6..0
- mem_data_addr  in  32  load/store effective address
- allow_interrupt  in  1  from cp0
- interrupt_flag  in  8  from cp0 (Status.IM & Cause.IP)
- epc_address  in  32  from cp0
- exp_en  out  1  cp0 exception write strobe
- exp_badvaddr_en  out  1  update BadVAddr
- exp_badvaddr  out  32  faulting address
- exp_bd  out  1  victim is in a delay slot
- exp_code  out  5  ExcCode
- exp_epc  out  32  EPC to record
- exl_clean  out  1  ERET: clear Status.EXL
- flush  out  1  kill all younger pipeline stages
- redirect_valid  out  1  fetch redirect request
- redirect_pc  out  32  redirect target
- redirect_ready  in  1  fetch accepts redirect

Behaviour:
- Commit condition: commit = mem_valid & ~mem_stall & (state == IDLE). exp_en = commit & (int_take | |mem_exc | mem_eret). exp_* outputs are combinational from MEM inputs in the same cycle, and are therefore sampled by cp0 at the same edge.
- Interrupt take: int_take = allow_interrupt & (interrupt_flag != 0).
- Priority, highest first, with ExcCode:
  - interrupt 0x00
  - if_adel 0x04 (badvaddr = mem_pc)
  - ri 0x0A
  - ov 0x0C
  - sys 0x08
  - bp 0x09
  - adel 0x04 (badvaddr = mem_data_addr)
  - ades 0x05 (badvaddr = mem_data_addr)
  - eret
  - exp_badvaddr_en is 1 only for the three address-error cases.
- Delay slot tracking:
  - Register in_ds is set when a non-excepting branch commits.
  - It is cleared when any other instruction commits, and on flush.
  - exp_bd = in_ds. exp_epc = in_ds ? mem_pc - 32'd4 : mem_pc (modulo 2^32).
- Branch victim: an exception on the branch itself gives exp_bd = 0 and EPC = branch PC.
- ERET: exp_en = 1, exl_clean = 1, exp_epc = epc_address (EPC preserved), exp_bd = 0, exp_code = 0x00, exp_badvaddr_en = 0. Cause.ExcCode is architecturally undefined after ERET.
- ERET with a pending interrupt: the interrupt wins and ERET is not executed.
- Any other taken event: exl_clean = 0.
- FSM states:
  - IDLE: on exp_en, go to REDIR. In the same cycle assert flush and load redirect_pc (EXC_VECTOR, or epc_address for ERET).
  - REDIR: redirect_valid = 1 and flush = 1. redirect_pc is stable. All MEM inputs are ignored and exp_en is forced to 0. On redirect_ready, return to IDLE next cycle.
- Redirect timing: fetch sees redirect_valid at the earliest one cycle after the exception commits.
- mem_stall with exception flags present: nothing fires; the event is re-evaluated each cycle until the stall drops.
- Reset (async, rst = 0), effective immediately, including mid-REDIR:
  - state = IDLE, redirect_valid = 0, redirect_pc = 0, in_ds = 0.
  - flush and exp_en are driven to 0 while in reset.
- Width rules: interrupt_flag is reduced with OR. All address arithmetic is 32-bit wrap.

Decomposition:
- Package exc_pkg:
  - ExcCode localparams (EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV).
  - mem_exc bit-index constants.
  - FSM state enum {IDLE, REDIR}.
- Sub-module exc_priority_enc: purely combinational. Flags + int_take + eret in, {valid, code, badvaddr_sel, is_eret} out. It is reused for the future TLB exception extension.

Test Plan:
- Overflow at pc = 0x8000_1000, in_ds = 0 → same cycle exp_en = 1, code = 0x0C, epc = 0x8000_1000, bd = 0, flush = 1. Next cycle redirect_valid = 1, pc = 0xBFC0_0380. Redirect_ready held low 3 cycles → valid held 3 cycles, exp_en stays 0.
- Branch at 0x100 commits, then delay slot at 0x104 with adel at mem_data_addr 0x0000_0003 → code = 0x04, bd = 1, epc = 0x100, badvaddr_en = 1, badvaddr = 0x3.
- interrupt_flag = 0x04, allow_interrupt = 1, together with sys on the same instruction → code = 0x00 (interrupt wins). With allow_interrupt = 0 → code = 0x08.
- ERET with epc_address = 0x8000_2000 → exl_clean = 1, exp_epc = 0x8000_2000. Then redirect_pc = 0x8000_2000.
- ri flag with mem_stall = 1 for 2 cycles → exp_en = 0 during the stall. exp_en = 1 in the first unstalled cycle.
- Reset asserted mid-REDIR, with redirect_ready never asserted → redirect_valid = 0 immediately (async). After release, state is IDLE and in_ds = 0; a delay-slot exception then reports bd = 0.
